mul_hilo_unit: RTL and testbench

- Sequential multiply / multiply-accumulate engine that owns the HI/LO register pair.
- Executes the mul and mad operations that ALU control decodes. Serves mfhi/mflo reads using ALU control's 2-bit sel code.
- Sits beside the ALU in the datapath. Tells the pipeline/control to stall when an HI/LO read is issued while a multiply is in flight.

---
 rtl/mul_hilo_unit.sv | 158 +++++++++++++++
 tb/tb_mul_hilo_unit.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_unit.sv
// mul_hilo_unit: sequential shift-add multiply / multiply-accumulate engine.
// It owns the HI/LO register pair, serves HI/LO reads for writeback, and
// raises stall when a HI/LO read arrives while an operation is in flight.
// One multiplier bit is consumed per clock, LSB first. The result is committed
// to HI/LO in a single write-back cycle after the last bit.
module mul_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             acc,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       sel,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

    // The counter carries one spare bit so that it can count up to WIDTH.
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = IW + 1;

    // These are the read-select codes from ALU control.
    localparam logic [1:0] SEL_HI = 2'b01;
    localparam logic [1:0] SEL_LO = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_WB   = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic                   acc_q, acc_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   done_q, done_d;

    // This is the multiplicand, zero-extended and aligned to the current bit.
    logic [2*WIDTH-1:0]     addend;
    // This is the partial product plus the aligned multiplicand when the current bit is set.
    logic [2*WIDTH-1:0]     prod_step;
    // This is the committed HI:LO plus the finished product. The sum wraps modulo 2^(2*WIDTH).
    logic [2*WIDTH-1:0]     hilo_sum;

    // Shift-add step: this term is added only when the current multiplier bit is 1.
    always_comb begin
        addend    = {{WIDTH{1'b0}}, a_q} << cnt_q;
        prod_step = prod_q;
        if (b_q[cnt_q[IW-1:0]]) begin
            prod_step = prod_q + addend;
        end
        hilo_sum  = {hi_q, lo_q} + prod_q;
    end

    // State register with asynchronous reset. A reset during an operation discards that operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, plus next values for the datapath and the done pulse.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // start is accepted only here. This includes the done cycle.
                if (start) begin
                    a_d     = src_a;
                    b_d     = src_b;
                    acc_d   = acc;
                    prod_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                // This cycle is the only place where HI/LO are written.
                if (acc_q) begin
                    {hi_d, lo_d} = hilo_sum;
                end else begin
                    {hi_d, lo_d} = prod_q;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and result registers. All of them clear on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= 1'b0;
            prod_q <= '0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    // Status and read port. The read path only ever shows the committed HI/LO.
    always_comb begin
        busy  = (state_q != ST_IDLE);
        stall = busy && ((sel == SEL_HI) || (sel == SEL_LO));
        case (sel)
            SEL_HI:  rd_data = hi_q;
            SEL_LO:  rd_data = lo_q;
            default: rd_data = '0;
        endcase
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule

// File: tb/tb_mul_hilo_unit.sv
// tb_mul_hilo_unit: directed-vector bench for mul_hilo_unit.
module tb_mul_hilo_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        acc;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [1:0]  sel;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    mul_hilo_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .acc     (acc),
        .src_a   (src_a),
        .src_b   (src_b),
        .sel     (sel),
        .busy    (busy),
        .done    (done),
        .stall   (stall),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start an operation. On return the bench is 1 time unit past the start edge E0.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ac);
        src_a = a;
        src_b = b;
        acc   = ac;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'hCAFE_F00D;
    endtask

    // Wait until done is high, up to 40 edges. lat is the number of edges waited after E0.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (!done) begin
            $display("FAIL wait_done: done=%0b after %0d edges, required done=1", done, lat);
            n_fail++;
        end
    endtask

    task automatic test_reset;
        n_checks++;
        if ({hi, lo} !== 64'd0 || busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
            $display("FAIL reset: hi=%h lo=%h busy=%b done=%b stall=%b, required all 0",
                     hi, lo, busy, done, stall);
            n_fail++;
        end
        $display("reset: hi=%h lo=%h busy=%b", hi, lo, busy);
    endtask

    task automatic test_mul_basic;
        int lat;
        issue(32'd3, 32'd5, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin
            $display("FAIL mul_busy_after_E0: busy=%b required 1", busy);
            n_fail++;
        end
        wait_done(lat);
        n_checks++;
        if (lat !== 33) begin
            $display("FAIL mul_latency: edges=%0d required 33", lat);
            n_fail++;
        end
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd15 || busy !== 1'b0) begin
            $display("FAIL mul_3x5: hi=%h lo=%h busy=%b, required hi=0 lo=f busy=0", hi, lo, busy);
            n_fail++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            $display("FAIL done_one_cycle: done=%b required 0", done);
            n_fail++;
        end
        $display("mul 3*5: hi=%h lo=%h latency=%0d", hi, lo, lat);
    endtask

    task automatic test_mul_max;
        int lat;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(lat);
        n_checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            $display("FAIL mul_max: hi=%h lo=%h, required hi=fffffffe lo=00000001", hi, lo);
            n_fail++;
        end
        $display("mul ffffffff*ffffffff: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_mad;
        int lat;
        issue(32'd3, 32'd5, 1'b0);
        wait_done(lat);
        issue(32'd2, 32'd4, 1'b1);
        wait_done(lat);
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd23) begin
            $display("FAIL mad_2x4: hi=%h lo=%h, required hi=0 lo=17", hi, lo);
            n_fail++;
        end
        $display("mad 15+2*4: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_wrap;
        int lat;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(lat);
        issue(32'hFFFF_FFFF, 32'd1, 1'b1);
        wait_done(lat);
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'h0000_0000) begin
            $display("FAIL mad_step1: hi=%h lo=%h, required hi=ffffffff lo=00000000", hi, lo);
            n_fail++;
        end
        issue(32'hFFFF_FFFF, 32'd1, 1'b1);
        // With the operation in flight, a HI read stalls and shows the old committed HI.
        sel = 2'b01;
        #1;
        n_checks++;
        if (stall !== 1'b1 || rd_data !== 32'hFFFF_FFFF) begin
            $display("FAIL stall_hi_busy: stall=%b rd_data=%h, required stall=1 rd_data=ffffffff",
                     stall, rd_data);
            n_fail++;
        end
        sel = 2'b00;
        wait_done(lat);
        n_checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFF) begin
            $display("FAIL mad_preload: hi=%h lo=%h, required all ones", hi, lo);
            n_fail++;
        end
        issue(32'd1, 32'd1, 1'b1);
        wait_done(lat);
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            $display("FAIL mad_wrap: hi=%h lo=%h, required hi=0 lo=0", hi, lo);
            n_fail++;
        end
        $display("mad wrap: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_read;
        int lat;
        issue(32'h1234_5678, 32'h0000_0010, 1'b0);
        wait_done(lat);
        // The expected product is 0x0000_0001_2345_6780.
        sel = 2'b10;
        #1;
        n_checks++;
        if (stall !== 1'b0 || rd_data !== 32'h2345_6780) begin
            $display("FAIL read_lo_idle: stall=%b rd_data=%h, required stall=0 rd_data=23456780",
                     stall, rd_data);
            n_fail++;
        end
        sel = 2'b01;
        #1;
        n_checks++;
        if (stall !== 1'b0 || rd_data !== 32'h0000_0001) begin
            $display("FAIL read_hi_idle: stall=%b rd_data=%h, required stall=0 rd_data=00000001",
                     stall, rd_data);
            n_fail++;
        end
        sel = 2'b11;
        #1;
        n_checks++;
        if (stall !== 1'b0 || rd_data !== 32'd0) begin
            $display("FAIL read_sel11: stall=%b rd_data=%h, required stall=0 rd_data=0", stall, rd_data);
            n_fail++;
        end
        issue(32'd3, 32'd3, 1'b0);
        #1;
        n_checks++;
        if (stall !== 1'b0 || rd_data !== 32'd0) begin
            $display("FAIL read_sel11_busy: stall=%b rd_data=%h, required stall=0 rd_data=0",
                     stall, rd_data);
            n_fail++;
        end
        sel = 2'b00;
        wait_done(lat);
        $display("read: sel checks done, hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_back_to_back;
        int lat;
        issue(32'd3, 32'd5, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        // A start at cycle 10 of the operation must be ignored.
        src_a = 32'd7;
        src_b = 32'd9;
        acc   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd15 || lat !== 23) begin
            $display("FAIL start_busy_ignored: hi=%h lo=%h edges=%0d, required hi=0 lo=f edges=23",
                     hi, lo, lat);
            n_fail++;
        end
        // Start again in the done cycle. This start must be accepted.
        issue(32'd2, 32'd4, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL start_in_done: busy=%b done=%b, required busy=1 done=0", busy, done);
            n_fail++;
        end
        wait_done(lat);
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd8 || lat !== 33) begin
            $display("FAIL back_to_back: hi=%h lo=%h edges=%0d, required hi=0 lo=8 edges=33",
                     hi, lo, lat);
            n_fail++;
        end
        $display("back_to_back: hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_reset_mid;
        int pulses;
        issue(32'd7, 32'd9, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_async: hi=%h lo=%h busy=%b done=%b, required all 0", hi, lo, busy, done);
            n_fail++;
        end
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        n_checks++;
        if (pulses !== 0 || hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            $display("FAIL reset_abort: done_pulses=%0d hi=%h lo=%h busy=%b, required 0 0 0 0",
                     pulses, hi, lo, busy);
            n_fail++;
        end
        $display("reset_mid: hi=%h lo=%h done_pulses=%0d", hi, lo, pulses);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        acc   = 1'b0;
        src_a = '0;
        src_b = '0;
        sel   = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_mul_basic();
        test_mul_max();
        test_mad();
        test_wrap();
        test_read();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
